// File: rtl/row_col_data_collector_if.sv
// ----------------------------------------------------------------------------
// row_col_data_collector_if
// Handshake/bus bundle between a row/column producer, the collector and the
// matrix consumer.
//   master : producer/consumer side (drives in_valid, row_col_datain, clear,
//            out_ready; observes in_ready, wr_index, out_valid, row_col_dataout)
//   slave  : the collector itself
// ----------------------------------------------------------------------------
interface row_col_data_collector_if #(
    parameter int DATA_WIDTH      = 16,
    parameter int ROW_COL_SIZE    = 16,
    parameter int MATRIX_SIZE     = 16,
    parameter int NUM_SELECT_BITS = $clog2(MATRIX_SIZE)
);
    logic                                         clear;
    logic                                         in_valid;
    logic                                         in_ready;
    logic [ROW_COL_SIZE*DATA_WIDTH-1:0]           row_col_datain;
    logic [NUM_SELECT_BITS-1:0]                   wr_index;
    logic                                         out_valid;
    logic                                         out_ready;
    logic [MATRIX_SIZE*ROW_COL_SIZE*DATA_WIDTH-1:0] row_col_dataout;

    modport master (
        output clear, in_valid, row_col_datain, out_ready,
        input  in_ready, wr_index, out_valid, row_col_dataout
    );

    modport slave (
        input  clear, in_valid, row_col_datain, out_ready,
        output in_ready, wr_index, out_valid, row_col_dataout
    );
endinterface

// File: rtl/row_col_data_collector.sv
// ----------------------------------------------------------------------------
// row_col_data_collector
// Collects MATRIX_SIZE rows/columns, one per valid/ready transfer, into slot
// storage and presents the flattened matrix downstream. Slot i sits at
// row_col_dataout[i*RCW +: RCW], matching the select mux layout.
//
// Ports
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : row_col_data_collector_if.slave
//            clear, in_valid/in_ready, row_col_datain, wr_index,
//            out_valid/out_ready, row_col_dataout
//
// Build option
//   ROW_COL_COLLECTOR_DOUBLE_BUFFER_EN : two ping-pong banks so filling can
//   continue while the previous matrix is held on the output.
// ----------------------------------------------------------------------------
module row_col_data_collector #(
    parameter int DATA_WIDTH      = 16,
    parameter int ROW_COL_SIZE    = 16,
    parameter int MATRIX_SIZE     = 16,
    parameter int NUM_SELECT_BITS = $clog2(MATRIX_SIZE)
) (
    input  logic                    clk,
    input  logic                    resetn,
    row_col_data_collector_if.slave bus
);
    localparam int RCW = ROW_COL_SIZE * DATA_WIDTH;
    localparam logic [NUM_SELECT_BITS-1:0] LAST_SLOT = NUM_SELECT_BITS'(MATRIX_SIZE - 1);

    // S_HOLD only exists with double buffering: one bank held, one filling.
    typedef enum logic [1:0] {S_FILL, S_HOLD, S_FULL} state_e;

    state_e                     state_q;
    logic [NUM_SELECT_BITS-1:0] wr_index_q;
    logic                       in_ready_q;
    logic                       out_valid_q;

    logic accept_w;
    logic complete_w;
    logic release_w;

`ifdef ROW_COL_COLLECTOR_DOUBLE_BUFFER_EN
    logic [1:0][MATRIX_SIZE-1:0][RCW-1:0] bank_q;
    logic                                 fill_bank_q;
    logic                                 out_bank_q;
`else
    logic [MATRIX_SIZE-1:0][RCW-1:0]      bank_q;
`endif

    assign accept_w   = bus.in_valid && in_ready_q && !bus.clear;
    assign complete_w = accept_w && (wr_index_q == LAST_SLOT);
    assign release_w  = out_valid_q && bus.out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_FILL;
            wr_index_q  <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ROW_COL_COLLECTOR_DOUBLE_BUFFER_EN
            fill_bank_q <= 1'b0;
            out_bank_q  <= 1'b0;
`endif
        end else begin
            if (bus.clear)
                wr_index_q <= '0;
            else if (accept_w)
                wr_index_q <= complete_w ? '0 : wr_index_q + 1'b1;

`ifdef ROW_COL_COLLECTOR_DOUBLE_BUFFER_EN
            // Invariant: fill and out pointers coincide while nothing is held
            // (S_FILL) and while both banks are full (S_FULL, input stalled).
            if (complete_w) fill_bank_q <= ~fill_bank_q;
            if (release_w)  out_bank_q  <= ~out_bank_q;
            case (state_q)
                S_FILL: if (complete_w) begin
                    state_q     <= S_HOLD;
                    out_valid_q <= 1'b1;
                end
                S_HOLD: begin
                    // Simultaneous release+complete: output swaps banks, stays valid.
                    if (complete_w && !release_w) begin
                        state_q    <= S_FULL;
                        in_ready_q <= 1'b0;
                    end else if (release_w && !complete_w) begin
                        state_q     <= S_FILL;
                        out_valid_q <= 1'b0;
                    end
                end
                S_FULL: if (release_w) begin
                    state_q    <= S_HOLD;
                    in_ready_q <= 1'b1;
                end
                default: state_q <= S_FILL;
            endcase
`else
            case (state_q)
                S_FILL: if (complete_w) begin
                    state_q     <= S_FULL;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b1;
                end
                S_FULL: if (release_w) begin
                    state_q     <= S_FILL;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
                default: state_q <= S_FILL;
            endcase
`endif
        end
    end

    // Slot storage; slots persist across matrices and are only overwritten.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            bank_q <= '0;
        else if (accept_w)
`ifdef ROW_COL_COLLECTOR_DOUBLE_BUFFER_EN
            bank_q[fill_bank_q][wr_index_q] <= bus.row_col_datain;
`else
            bank_q[wr_index_q] <= bus.row_col_datain;
`endif
    end

    // in_ready resets to 1 but must read 0 while reset is held.
    assign bus.in_ready  = in_ready_q & resetn;
    assign bus.out_valid = out_valid_q;
    assign bus.wr_index  = wr_index_q;
`ifdef ROW_COL_COLLECTOR_DOUBLE_BUFFER_EN
    assign bus.row_col_dataout = bank_q[out_bank_q];
`else
    assign bus.row_col_dataout = bank_q;
`endif

endmodule

// File: tb/tb_row_col_data_collector.sv
module tb_row_col_data_collector;
    logic clk;
    logic resetn;
    int   vectors;
    int   miscompares;
    int   acc;
    int   ovc;
    int   stalls;

    row_col_data_collector_if bus ();

    row_col_data_collector dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rowpat(input logic [15:0] v);
        return {16{v}};
    endfunction

    function automatic logic [255:0] slot(input int i);
        return bus.row_col_dataout[i*256 +: 256];
    endfunction

    task automatic chk_zero_out(input string tag);
        chk(tag, {255'b0, |bus.row_col_dataout}, 256'd0);
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        resetn         = 1'b0;
        bus.clear      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b0;
        bus.row_col_datain = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_in_ready_low", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_wr_index", bus.wr_index, 0);
        chk_zero_out("rst_dout");
        #2 resetn = 1'b1;
        tick();
        chk("post_rst_in_ready", bus.in_ready, 1);

`ifndef ROW_COL_COLLECTOR_DOUBLE_BUFFER_EN
        // ---------------- 16 back-to-back rows, out_ready=0 ----------------
        for (int r = 0; r < 16; r++) begin
            bus.in_valid = 1'b1;
            bus.row_col_datain = rowpat(16'(r));
            tick();
            if (r == 5) begin
                chk("wlat_slot5", slot(5), rowpat(16'h0005));
                chk("wr_index_6", bus.wr_index, 6);
            end
            if (r == 14) chk("not_valid_at_15", bus.out_valid, 0);
        end
        chk("full_out_valid", bus.out_valid, 1);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_wr_index", bus.wr_index, 0);
        chk("full_slot5", slot(5), rowpat(16'h0005));
        chk("full_slot0", slot(0), rowpat(16'h0000));
        chk("full_slot15", slot(15), rowpat(16'h000F));

        // Input stalls while held; new data must not enter
        bus.row_col_datain = rowpat(16'hBEEF);
        tick();
        tick();
        chk("hold_slot0", slot(0), rowpat(16'h0000));
        chk("hold_out_valid", bus.out_valid, 1);
        // clear while FULL does not disturb the hold
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        chk("clear_full_valid", bus.out_valid, 1);
        chk("clear_full_slot9", slot(9), rowpat(16'h0009));

        // handoff
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("handoff_out_valid", bus.out_valid, 0);
        chk("handoff_in_ready", bus.in_ready, 1);
        tick();
        chk("one_valid_per_pulse", bus.out_valid, 0);

        // ---------------- random gaps ----------------
        for (int r = 0; r < 16; r++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            bus.in_valid = 1'b0;
            for (int g = 0; g < gap; g++) tick();
            bus.in_valid = 1'b1;
            bus.row_col_datain = rowpat(16'h0100 + 16'(r));
            tick();
            if (r == 14) chk("gap_not_early", bus.out_valid, 0);
        end
        bus.in_valid = 1'b0;
        chk("gap_out_valid", bus.out_valid, 1);
        for (int i = 0; i < 16; i++)
            chk($sformatf("gap_slot%0d", i), slot(i), rowpat(16'h0100 + 16'(i)));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("gap_release", bus.out_valid, 0);

        // ---------------- clear drops concurrent row ----------------
        for (int r = 0; r < 7; r++) begin
            bus.in_valid = 1'b1;
            bus.row_col_datain = rowpat(16'h0E00 + 16'(r));
            tick();
        end
        chk("pre_clear_index", bus.wr_index, 7);
        bus.clear = 1'b1;
        bus.row_col_datain = rowpat(16'hDEAD);
        tick();
        bus.clear = 1'b0;
        chk("clear_index", bus.wr_index, 0);
        chk("clear_drop_slot7", slot(7), rowpat(16'h0107));
        chk("clear_keeps_slot6", slot(6), rowpat(16'h0E06));
        for (int r = 0; r < 16; r++) begin
            bus.row_col_datain = rowpat(16'hA5A5);
            tick();
            if (r == 14) chk("a5_not_early", bus.out_valid, 0);
        end
        bus.in_valid = 1'b0;
        chk("a5_out_valid", bus.out_valid, 1);
        chk("a5_all", {255'b0, bus.row_col_dataout === {256{16'hA5A5}}}, 256'd1);

        // ---------------- async reset during FULL ----------------
        #2 resetn = 1'b0;
        #1;
        chk("arst_full_valid", bus.out_valid, 0);
        chk("arst_full_index", bus.wr_index, 0);
        chk("arst_full_ready", bus.in_ready, 0);
        chk_zero_out("arst_full_dout");
        #3 resetn = 1'b1;
        tick();

        // ---------------- async reset mid-fill ----------------
        for (int r = 0; r < 9; r++) begin
            bus.in_valid = 1'b1;
            bus.row_col_datain = rowpat(16'h0900 + 16'(r));
            tick();
        end
        bus.in_valid = 1'b0;
        chk("midfill_index", bus.wr_index, 9);
        #2 resetn = 1'b0;
        #1;
        chk("arst_mid_index", bus.wr_index, 0);
        chk_zero_out("arst_mid_dout");
        #3 resetn = 1'b1;
        tick();

        // ---------------- throughput, out_ready tied high ----------------
        acc = 0;
        ovc = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 34; c++) begin
            bus.in_valid = 1'b1;
            bus.row_col_datain = rowpat(16'h2000 + 16'(acc));
            if (bus.in_ready) acc++;
            if (bus.out_valid) ovc++;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        chk("tput_accepts", 256'(acc), 256'd32);
        chk("tput_valid_cycles", 256'(ovc), 256'd2);
        chk("tput_slot15", slot(15), rowpat(16'h201F));
`else
        // ---------------- double buffer: 32 rows before stall ----------------
        for (int r = 0; r < 32; r++) begin
            bus.in_valid = 1'b1;
            bus.row_col_datain = rowpat(16'h1000 + 16'(r));
            if (r == 31) chk("db_ready_before_32", bus.in_ready, 1);
            tick();
            if (r == 15) chk("db_valid_at_16", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        chk("db_in_ready_0", bus.in_ready, 0);
        chk("db_out_valid", bus.out_valid, 1);
        chk("db_m1_slot3", slot(3), rowpat(16'h1003));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("db_swap_valid", bus.out_valid, 1);
        chk("db_swap_ready", bus.in_ready, 1);
        chk("db_m2_slot3", slot(3), rowpat(16'h1013));
        bus.out_ready = 1'b1;
        tick();
        chk("db_drain", bus.out_valid, 0);

        // ---------------- double buffer: 48 back-to-back ----------------
        ovc = 0;
        stalls = 0;
        for (int r = 0; r < 48; r++) begin
            bus.in_valid = 1'b1;
            bus.row_col_datain = rowpat(16'h3000 + 16'(r));
            if (!bus.in_ready) stalls++;
            if (bus.out_valid) ovc++;
            tick();
        end
        bus.in_valid = 1'b0;
        if (bus.out_valid) ovc++;
        bus.out_ready = 1'b0;
        chk("db_stalls", 256'(stalls), 256'd0);
        chk("db_matrices", 256'(ovc), 256'd3);
        chk("db_m3_slot0", slot(0), rowpat(16'h3020));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/row_col_data_collector.md
# row_col_data_collector

Sequential write-side counterpart to the matrix row/column select mux. The block accepts one row or column per transfer over a valid/ready handshake and stores it into matrix slot storage. Once `MATRIX_SIZE` slots are filled, it presents the whole flattened matrix downstream. Slot `i` occupies the same bit range that the select mux returns for `select = i`, so collector output drives mux input directly. The block sits between the row/column producers of the matrix-multiply datapath and the matrix operand registers.

## Interface
- `DATA_WIDTH`, 16, bits per element
- `ROW_COL_SIZE`, 16, elements per row/column
- `MATRIX_SIZE`, 16, rows/columns per matrix; must be ≥2
- `NUM_SELECT_BITS`, `$clog2(MATRIX_SIZE)`, slot index width
- `clk`  in  1  single clock; all logic on rising edge
- `resetn`  in  1  asynchronous active-low reset
- `clear`  in  1  synchronous abort of the partial fill
- `in_valid`  in  1  row/column present
- `in_ready`  out  1  collector can accept
- `row_col_datain`  in  `ROW_COL_SIZE*DATA_WIDTH`  row/column payload
- `wr_index`  out  `NUM_SELECT_BITS`  slot the next accepted transfer writes
- `out_valid`  out  1  full matrix available
- `out_ready`  in  1  consumer takes the matrix
- `row_col_dataout`  out  `MATRIX_SIZE*ROW_COL_SIZE*DATA_WIDTH`  flattened matrix; slot `i` at `[i*RCW +: RCW]`, where `RCW = ROW_COL_SIZE*DATA_WIDTH`

## Operation
- Reset values:
  - FSM in FILL
  - `wr_index` = 0
  - `in_ready` = 1 (registered; held 0 while `resetn` is low)
  - `out_valid` = 0
  - all storage and `row_col_dataout` = 0
- FILL state:
  - `in_ready` = 1.
  - Accept condition is `in_valid && in_ready && !clear`.
  - On accept, slot `wr_index` is written and `wr_index` increments.
  - Accepting at `wr_index == MATRIX_SIZE-1` wraps `wr_index` to 0 and moves the FSM to FULL.
- FULL state:
  - `in_ready` = 0, `out_valid` = 1.
  - `row_col_dataout` is held stable.
  - `out_ready` returns the FSM to FILL.
- Slots are never cleared between matrices. The output only becomes valid after every slot has been rewritten.
- `clear`:
  - Forces `wr_index` to 0.
  - A row presented in the same cycle is discarded, not written, even if `in_valid` is high.
  - Does not affect `out_valid` or the held output in FULL.
- `in_valid` without `in_ready` is a wait; the producer must hold its data.
- `resetn` asserted mid-fill or mid-hold aborts immediately, with all values as at reset.

## Timing
- Write latency: the payload is visible in `row_col_dataout` one cycle after the accept edge.
- Output latency: `out_valid` rises on the same edge that accepts slot `MATRIX_SIZE-1`.
- Handoff: on the edge where `out_valid && out_ready`, `out_valid` falls and `in_ready` rises. In single-buffer builds the next accept is possible one cycle later.
- Throughput:
  - Single-buffer: `MATRIX_SIZE + 1` cycles per matrix, with `out_ready` tied high.
  - Double-buffer: `MATRIX_SIZE` cycles per matrix.
- No combinational path from `in_valid` to `in_ready` or from `out_ready` to `out_valid`.

## Configuration
- `ROW_COL_COLLECTOR_DOUBLE_BUFFER_EN`
- Undefined: a single storage bank. Input stalls (`in_ready` = 0) for the whole FULL hold.
- Defined: two banks, ping-pong.
  - Completing a fill hands the bank to the output side.
  - Filling continues into the other bank.
  - `in_ready` drops only when both banks are full.
  - If the output bank is released (`out_ready`) on the same edge that completes the other bank, `out_valid` stays 1 and the output switches to the newly completed bank.
  - `clear` affects only the filling bank.

## Test plan
- Reset, then 16 back-to-back rows with each element equal to row index (0..15), `out_ready` = 0 → `out_valid` = 1 after the 16th accept; slot 5 of `row_col_dataout` reads all 0x0005; `in_ready` = 0; `wr_index` = 0.
- Random `in_valid` gaps plus `out_ready` pulse while FULL → exactly one `out_valid` cycle per pulse; slot order matches accept order; no row lost or duplicated.
- Write 7 rows, assert `clear` concurrently with an 8th valid row, then write 16 rows of 0xA5A5 → that 8th row is dropped; after 16 more accepts the output is all 0xA5A5; `wr_index` was 0 after `clear`.
- Drop `resetn` during FULL and again asynchronously mid-fill (`wr_index` = 9) → `out_valid` = 0, `wr_index` = 0, output = 0 immediately, without waiting for a clock edge.
- Double-buffer build, `out_ready` held 0 → 32 rows accepted before `in_ready` = 0; a single `out_ready` pulse switches the output to the second matrix and `in_ready` returns to 1.
- Double-buffer build, `out_ready` = 1 continuously with 48 back-to-back rows → three matrices, `out_valid` pulses every 16 cycles, zero input stall cycles.
